// File: rtl/fp_mult_pkg.sv
// +------------------------------------------------------------------+
// | fp_mult_pkg: shared types/constants for the FP multiplier path.  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

package fp_mult_pkg;

  localparam int MW_DEFAULT = 24;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } mult_state_t;

endpackage

`default_nettype wire

// File: rtl/mant_norm_gs.sv
// +------------------------------------------------------------------+
// | mant_norm_gs: 1-position product normalize with guard/sticky.    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module mant_norm_gs #(
  parameter int MW = 24
) (
  input  logic [2*MW-1:0] product,
  output logic [MW:0]     mant,
  output logic            guard,
  output logic            sticky,
  output logic            exp_inc
);

  // Product of two [1,2) mantissas lies in [1,4); only the top bit decides the shift.
  always_comb begin
    mant    = '0;
    guard   = 1'b0;
    sticky  = 1'b0;
    exp_inc = 1'b0;
    if (product[2*MW-1]) begin
      mant    = {1'b0, product[2*MW-1:MW]};
      guard   = product[MW-1];
      sticky  = |product[MW-2:0];
      exp_inc = 1'b1;
    end else begin
      mant    = {1'b0, product[2*MW-2:MW-1]};
      guard   = product[MW-2];
      sticky  = |product[MW-3:0];
      exp_inc = 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mant_mult_seq.sv
// +------------------------------------------------------------------+
// | mant_mult_seq: sequential shift-add mantissa multiplier.         |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module mant_mult_seq
  import fp_mult_pkg::*;
#(
  parameter int MW = MW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [MW-1:0] a_mant,
  input  logic [MW-1:0] b_mant,
  input  logic          a_sign,
  input  logic          b_sign,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [MW:0]   mant_out,
  output logic          guard,
  output logic          sticky,
  output logic          sign,
  output logic          exp_inc
);

  localparam int CW = $clog2(MW);

  mult_state_t     state;
  logic [MW-1:0]   mplier;
  logic [2*MW-1:0] mcand;
  logic [2*MW-1:0] acc;
  logic [CW-1:0]   cnt;
  logic            sign_lat;

  logic [MW:0]     norm_mant;
  logic            norm_guard;
  logic            norm_sticky;
  logic            norm_exp_inc;

  mant_norm_gs #(.MW(MW)) u_norm (
    .product (acc),
    .mant    (norm_mant),
    .guard   (norm_guard),
    .sticky  (norm_sticky),
    .exp_inc (norm_exp_inc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      mant_out  <= '0;
      guard     <= 1'b0;
      sticky    <= 1'b0;
      sign      <= 1'b0;
      exp_inc   <= 1'b0;
      mplier    <= '0;
      mcand     <= '0;
      acc       <= '0;
      cnt       <= '0;
      sign_lat  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mplier   <= b_mant;
            mcand    <= {{MW{1'b0}}, a_mant};
            acc      <= '0;
            cnt      <= '0;
            sign_lat <= a_sign ^ b_sign;
            in_ready <= 1'b0;
            state    <= MUL;
          end
        end
        MUL: begin
          // The multiplicand register carries the shift-by-counter implicitly.
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
          if (cnt == CW'(MW - 1)) state <= NORM;
        end
        NORM: begin
          mant_out  <= norm_mant;
          guard     <= norm_guard;
          sticky    <= norm_sticky;
          exp_inc   <= norm_exp_inc;
          sign      <= sign_lat;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mant_mult_seq.sv
// +------------------------------------------------------------------+
// | tb_mant_mult_seq: vector table, random model, handshake/reset.   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module tb_mant_mult_seq;

  localparam int MW = 24;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [MW-1:0] a_mant = '0;
  logic [MW-1:0] b_mant = '0;
  logic          a_sign = 1'b0;
  logic          b_sign = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [MW:0]   mant_out;
  logic          guard;
  logic          sticky;
  logic          sign;
  logic          exp_inc;

  int n_checks = 0;
  int n_fail   = 0;

  mant_mult_seq #(.MW(MW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_mant    (a_mant),
    .b_mant    (b_mant),
    .a_sign    (a_sign),
    .b_sign    (b_sign),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .mant_out  (mant_out),
    .guard     (guard),
    .sticky    (sticky),
    .sign      (sign),
    .exp_inc   (exp_inc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [MW-1:0] a;
    logic [MW-1:0] b;
    logic          sa;
    logic          sb;
    logic [MW:0]   m;
    logic          g;
    logic          s;
    logic          e;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: real product, then divide/modulo to pick the rounding fields.
  task automatic model(input logic [MW-1:0] a, input logic [MW-1:0] b,
                       output logic [MW:0] m, output logic g, output logic s, output logic e);
    longint unsigned p;
    longint unsigned two_mw;
    p = longint'(a) * longint'(b);
    two_mw = 64'd1 << (2*MW - 1);
    if (p >= two_mw) begin
      e = 1'b1;
      m = (MW+1)'(p / (64'd1 << MW));
      g = ((p / (64'd1 << (MW-1))) % 2) != 0;
      s = (p % (64'd1 << (MW-1))) != 0;
    end else begin
      e = 1'b0;
      m = (MW+1)'(p / (64'd1 << (MW-1)));
      g = ((p / (64'd1 << (MW-2))) % 2) != 0;
      s = (p % (64'd1 << (MW-2))) != 0;
    end
  endtask

  // Issue one operation and wait for out_valid; leaves the result pending in DONE.
  task automatic issue(input logic [MW-1:0] a, input logic [MW-1:0] b,
                       input logic sa, input logic sb, output int lat);
    int w;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) check("in_ready_timeout", 0, 1);
    a_mant = a; b_mant = b; a_sign = sa; b_sign = sb;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic release_result();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("release_out_valid", out_valid, 0);
    check("release_in_ready", in_ready, 1);
  endtask

  task automatic run_and_check(input string tag, input logic [MW-1:0] a, input logic [MW-1:0] b,
                               input logic sa, input logic sb, input logic [MW:0] m,
                               input logic g, input logic s, input logic e);
    int lat;
    issue(a, b, sa, sb, lat);
    check({tag, "_latency"}, lat, MW + 1);
    check({tag, "_mant"}, mant_out, m);
    check({tag, "_guard"}, guard, g);
    check({tag, "_sticky"}, sticky, s);
    check({tag, "_exp_inc"}, exp_inc, e);
    check({tag, "_sign"}, sign, sa ^ sb);
    release_result();
  endtask

  initial begin
    logic [MW:0]   em;
    logic          eg, es, ee;
    logic [MW-1:0] ra, rb;
    logic          rsa, rsb;
    logic [MW:0]   held_m;
    int            lat;

    vecs[0] = '{24'h800000, 24'h800000, 1'b0, 1'b0, 25'h0800000, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{24'hC00000, 24'hC00000, 1'b0, 1'b1, 25'h0900000, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{24'hFFFFFF, 24'hFFFFFF, 1'b1, 1'b1, 25'h0FFFFFE, 1'b0, 1'b1, 1'b1};
    vecs[3] = '{24'h800001, 24'hC00000, 1'b1, 1'b0, 25'h0C00001, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{24'h000000, 24'hABCDEF, 1'b0, 1'b0, 25'h0000000, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{24'h9A5A5A, 24'h000000, 1'b1, 1'b0, 25'h0000000, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{24'h800000, 24'hFFFFFF, 1'b0, 1'b0, 25'h0FFFFFF, 1'b0, 1'b0, 1'b0};

    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_mant", mant_out, 0);
    check("rst_flags", {guard, sticky, sign, exp_inc}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++)
      run_and_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sa, vecs[i].sb,
                    vecs[i].m, vecs[i].g, vecs[i].s, vecs[i].e);

    for (int i = 0; i < 20; i++) begin
      ra  = MW'($urandom) | (i < 16 ? 24'h800000 : 24'h000000);
      rb  = MW'($urandom) | (i < 16 ? 24'h800000 : 24'h000000);
      rsa = 1'($urandom);
      rsb = 1'($urandom);
      model(ra, rb, em, eg, es, ee);
      run_and_check($sformatf("rnd%0d", i), ra, rb, rsa, rsb, em, eg, es, ee);
    end

    // Back-pressure: result held, new operands ignored.
    issue(24'hC00000, 24'hC00000, 1'b0, 1'b1, lat);
    check("hold_latency", lat, MW + 1);
    held_m = mant_out;
    check("hold_first_mant", held_m, 25'h0900000);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      a_mant = 24'hFFFFFF; b_mant = 24'hFFFFFF; a_sign = 1'b0; b_sign = 1'b0;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      check("hold_stable", {out_valid, in_ready, mant_out, guard, sticky, sign, exp_inc},
            {1'b1, 1'b0, 25'h0900000, 1'b0, 1'b0, 1'b1, 1'b1});
    end
    in_valid = 1'b0;
    release_result();
    repeat (5) @(posedge clk);
    #1;
    check("hold_no_phantom", out_valid, 0);

    // Reset during MUL at counter=10.
    @(negedge clk);
    a_mant = 24'hFFFFFF; b_mant = 24'hFFFFFF; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("pre_rst_busy", in_ready, 0);
    rst_n = 1'b0;
    #1;
    check("async_rst_in_ready", in_ready, 1);
    check("async_rst_out_valid", out_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    check("aborted_no_result", out_valid, 0);
    run_and_check("post_rst", 24'h800001, 24'hC00000, 1'b0, 1'b0, 25'h0C00001, 1'b1, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mant_mult_seq.md
Name: mant_mult_seq

Overview:
- Sequential shift-add mantissa multiplier; producer feeding the FP multiplier rounding stage.
- Multiplies two MW-bit mantissas (hidden bit included) over MW cycles.
- Normalizes the 2*MW-bit product by at most one position and emits a (MW+1)-bit mantissa, guard, sticky and exponent-increment flag, ready for rounding.
- Valid/ready handshakes on both sides; one operation in flight.

Parameters:
- MW, 24, mantissa width incl. hidden bit; product width 2*MW; output mantissa width MW+1

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands valid
- in_ready  out  1  block can accept operands
- a_mant  in  MW  operand A mantissa, hidden bit at MSB
- b_mant  in  MW  operand B mantissa
- a_sign  in  1  sign of A
- b_sign  in  1  sign of B
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- mant_out  out  MW+1  normalized mantissa; bit MW always 0 (carry slot for rounding)
- guard  out  1  first bit below mant_out LSB
- sticky  out  1  OR of all bits below guard
- sign  out  1  a_sign ^ b_sign
- exp_inc  out  1  1 when product was in [2,4) and was shifted right by one

Behaviour:
- Reset (async, rst_n=0): state=IDLE, in_ready=1, out_valid=0, mant_out=0, guard=0, sticky=0, sign=0, exp_inc=0, counter=0, accumulator=0. Reset mid-operation aborts it; no result is produced.
- States: IDLE, MUL, NORM, DONE.
- IDLE: in_ready=1. On in_valid&in_ready edge: latch a_mant, b_mant, a_sign^b_sign; clear 2*MW-bit accumulator; counter=0; go to MUL.
- MUL: in_ready=0. Each cycle: if multiplier LSB=1, add multiplicand (shifted by counter) to accumulator; shift multiplier right; counter++. After MW cycles (counter==MW-1 on that edge), go to NORM. Accumulator width 2*MW; no overflow is possible.
- NORM (1 cycle): with P = product:
  - If P[2MW-1]=1: mant_out={0,P[2MW-1:MW]}, guard=P[MW-1], sticky=|P[MW-2:0], exp_inc=1.
  - Else: mant_out={0,P[2MW-2:MW-1]}, guard=P[MW-2], sticky=|P[MW-3:0], exp_inc=0.
  - Register the outputs; out_valid=1; go to DONE.
- No further normalization for denormal operands (handled upstream); a zero operand gives an all-zero mantissa, guard=0, sticky=0, exp_inc=0.
- DONE: out_valid=1; all outputs held stable while out_ready=0. On out_ready=1: out_valid=0, go to IDLE.
- Latency: out_valid is high after the MW+1th rising edge following the accepting edge (25 for MW=24).
- Throughput: one result per MW+3 cycles minimum.
- in_valid while not in IDLE is ignored; operands are not sampled.
- in_ready is registered from state only (no combinational path from out_ready).
- Outputs other than out_valid are don't-care-but-stable outside DONE (they keep their last values).

Decomposition:
- Shared package fp_mult_pkg: state enum (IDLE, MUL, NORM, DONE) and MW default constant.
- One natural sub-module: mant_norm_gs (combinational NORM logic: product -> mant_out, guard, sticky, exp_inc). It is reusable by a future array multiplier.

Test Plan:
- a=b=0x800000 (1.0*1.0) -> after 25 cycles: mant_out=0x0800000, guard=0, sticky=0, exp_inc=0.
- a=b=0xC00000 (1.5*1.5), signs 0/1 -> mant_out=0x0900000, guard=0, sticky=0, exp_inc=1, sign=1.
- a=b=0xFFFFFF -> mant_out=0x0FFFFFE, guard=0, sticky=1, exp_inc=1.
- a=0x800001, b=0xC00000 -> mant_out=0x0C00001, guard=1, sticky=0, exp_inc=0.
- Hold out_ready=0 for 10 cycles in DONE and pulse in_valid with new operands -> outputs stable, in_ready=0, new operands ignored. Raise out_ready -> next cycle out_valid=0, in_ready=1.
- Assert rst_n=0 at MUL counter=10 -> immediately in_ready=1, out_valid=0. A fresh operation after release gives the correct result with 25-cycle latency.
